// File: rtl/qsys_led_sequencer.sv
// rtl/qsys_led_sequencer.sv - Avalon-MM LED pattern sequencer with CSR slave and PIO write master
//
// Purpose: animates an LED PIO without CPU involvement. Software programs
// enable/mode/period through the CSR slave. The block then issues timed
// master writes of LED patterns to the PIO data register.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   address         CSR word address (0 CTRL, 1 PERIOD, 2 STATUS, 3 STEPS)
//   chipselect      CSR select
//   write_n         CSR write strobe, active low
//   writedata       CSR write data
//   readdata        CSR read data, combinational (read latency 0)
//   m_address       master address, constant PIO_ADDR
//   m_write         master write request
//   m_writedata     master write data, {zeros, pattern}
//   m_waitrequest   slave stall; a write is accepted when m_write & ~m_waitrequest
module qsys_led_sequencer #(
  parameter int         LED_W    = 4,
  parameter int         PER_W    = 24,
  parameter logic [1:0] PIO_ADDR = 2'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_write,
  output logic [31:0] m_writedata,
  input  logic        m_waitrequest
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_CLEAR = 2'd3;

  localparam logic [1:0] MODE_LEFT   = 2'b00;
  localparam logic [1:0] MODE_RIGHT  = 2'b01;
  localparam logic [1:0] MODE_BLINK  = 2'b10;

  localparam logic [LED_W-1:0] PAT_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] PAT_ONES = {LED_W{1'b1}};

  logic [1:0]       state;
  logic             ctrl_en;
  logic [1:0]       ctrl_mode;
  logic [PER_W-1:0] period;
  logic [PER_W-1:0] period_cur;   // period snapshot taken at each counter reload
  logic [PER_W-1:0] count;
  logic [PER_W-1:0] count_last;
  logic [LED_W-1:0] pattern;
  logic [LED_W-1:0] next_pat;
  logic             dir;          // 0 = moving toward MSB, 1 = toward LSB
  logic             next_dir;
  logic [31:0]      steps;
  logic             csr_wr;
  logic             accept;
  logic             onehot;

  assign csr_wr = chipselect & ~write_n;
  assign accept = m_write & ~m_waitrequest;
  assign onehot = $onehot(pattern);

  // A zero period behaves as a period of one cycle.
  assign count_last = (period_cur == '0) ? '0 : period_cur - PER_W'(1);

  if (PER_W < 32) begin : g_wd_hi
    logic unused_wd;
    assign unused_wd = ^writedata[31:PER_W];
  end

  // Next pattern per mode. A pattern left over from another mode that is not
  // one-hot restarts the shifting modes at bit 0.
  always_comb begin
    next_pat = pattern;
    next_dir = dir;
    case (ctrl_mode)
      MODE_LEFT:  next_pat = onehot ? ((pattern << 1) | (pattern >> (LED_W - 1))) : PAT_ONE;
      MODE_RIGHT: next_pat = onehot ? ((pattern >> 1) | (pattern << (LED_W - 1))) : PAT_ONE;
      MODE_BLINK: next_pat = (pattern == PAT_ONES) ? '0 : PAT_ONES;
      default: begin
        // Bounce: direction flips when leaving an end so no end pattern repeats.
        if (!onehot) begin
          next_pat = PAT_ONE;
          next_dir = 1'b0;
        end else if (LED_W == 1) begin
          next_pat = pattern;
        end else if (!dir) begin
          if (pattern[LED_W-1]) begin
            next_dir = 1'b1;
            next_pat = pattern >> 1;
          end else begin
            next_pat = pattern << 1;
          end
        end else begin
          if (pattern[0]) begin
            next_dir = 1'b0;
            next_pat = pattern << 1;
          end else begin
            next_pat = pattern >> 1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 2'b00;
      period    <= PER_W'(1);
    end else if (csr_wr) begin
      case (address)
        2'd0: begin
          ctrl_en   <= writedata[0];
          ctrl_mode <= writedata[2:1];
        end
        2'd1:    period <= writedata[PER_W-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      pattern    <= '0;
      dir        <= 1'b0;
      count      <= '0;
      period_cur <= PER_W'(1);
      steps      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl_en) begin
            pattern    <= (ctrl_mode == MODE_BLINK) ? PAT_ONES : PAT_ONE;
            dir        <= 1'b0;
            count      <= '0;
            period_cur <= period;
            state      <= ST_WRITE;
          end
        end
        ST_WAIT: begin
          if (!ctrl_en) begin
            state <= ST_CLEAR;
          end else if (count == count_last) begin
            pattern <= next_pat;
            dir     <= next_dir;
            state   <= ST_WRITE;
          end else begin
            count <= count + PER_W'(1);
          end
        end
        ST_WRITE: begin
          // A pending write is always completed before honouring a disable.
          if (accept) begin
            steps      <= steps + 32'd1;
            count      <= '0;
            period_cur <= period;
            state      <= ctrl_en ? ST_WAIT : ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          if (accept) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign m_address   = PIO_ADDR;
  assign m_write     = (state == ST_WRITE) || (state == ST_CLEAR);
  assign m_writedata = (state == ST_WRITE) ? 32'(pattern) : 32'd0;

  always_comb begin
    readdata = 32'd0;
    case (address)
      2'd0: readdata = {29'd0, ctrl_mode, ctrl_en};
      2'd1: readdata = 32'(period);
      2'd2: begin
        readdata[LED_W+3:4] = pattern;
        readdata[1]         = dir;
        readdata[0]         = (state == ST_WRITE);
      end
      default: readdata = steps;
    endcase
  end

endmodule

// File: tb/tb_qsys_led_sequencer.sv
// tb/tb_qsys_led_sequencer.sv - directed self-checking bench for qsys_led_sequencer
module tb_qsys_led_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [1:0]  m_address;
  logic        m_write;
  logic [31:0] m_writedata;
  logic        m_waitrequest;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] wlog_data[$];
  int          wlog_cyc[$];
  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic [31:0] steps_before;

  always #5 clk = ~clk;

  qsys_led_sequencer #(.LED_W(4), .PER_W(24), .PIO_ADDR(2'd0)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .readdata     (readdata),
    .m_address    (m_address),
    .m_write      (m_write),
    .m_writedata  (m_writedata),
    .m_waitrequest(m_waitrequest)
  );

  always @(posedge clk) begin
    if (!reset && m_write && !m_waitrequest) begin
      wlog_data.push_back(m_writedata);
      wlog_cyc.push_back(cyc);
    end
    cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick();
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_writes(input string tag, input int n, input int budget);
    int k = 0;
    while (wlog_data.size() < n && k < budget) begin
      tick();
      k++;
    end
    check_eq({tag, "_count"}, 32'(wlog_data.size()), 32'(n));
  endtask

  task automatic wait_mwrite(input string tag, input int budget);
    int k = 0;
    while (m_write !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    check_eq({tag, "_mwrite_seen"}, {31'd0, m_write}, 32'd1);
  endtask

  // Compares the write log against exp_q; gap > 0 also checks cycle spacing.
  task automatic check_log(input string tag, input int gap);
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq($sformatf("%s_data%0d", tag, i),
               (i < wlog_data.size()) ? wlog_data[i] : 32'hDEAD_BEEF, exp_q[i]);
      if (gap > 0 && i > 0)
        check_eq($sformatf("%s_gap%0d", tag, i),
                 (i < wlog_cyc.size()) ? 32'(wlog_cyc[i] - wlog_cyc[i-1]) : 32'hDEAD_BEEF,
                 32'(gap));
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    address       = 2'd0;
    chipselect    = 1'b0;
    write_n       = 1'b1;
    writedata     = 32'd0;
    m_waitrequest = 1'b0;
    tick(3);
    reset = 1'b0;
    tick();

    // Reset state
    check_eq("rst_m_write", {31'd0, m_write}, 32'd0);
    check_eq("rst_m_writedata", m_writedata, 32'd0);
    check_eq("rst_m_address", {30'd0, m_address}, 32'd0);
    csr_read(2'd0, rd); check_eq("rst_ctrl", rd, 32'd0);
    csr_read(2'd1, rd); check_eq("rst_period", rd, 32'd1);
    csr_read(2'd2, rd); check_eq("rst_status", rd, 32'd0);
    csr_read(2'd3, rd); check_eq("rst_steps", rd, 32'd0);

    // Chase-left, period 4: one write every 5 cycles
    csr_write(2'd1, 32'd4);
    csr_read(2'd1, rd); check_eq("period_rb", rd, 32'd4);
    wlog_data.delete(); wlog_cyc.delete();
    csr_write(2'd0, 32'd1);
    wait_writes("chase", 5, 100);
    exp_q = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd1};
    check_log("chase", 5);
    csr_read(2'd3, rd); check_eq("chase_steps", rd, 32'd5);
    csr_write(2'd0, 32'd0);
    tick(10);
    check_eq("chase_clear_last", (wlog_data.size() > 0) ? wlog_data[$] : 32'hDEAD_BEEF, 32'd0);
    check_eq("chase_idle_mwrite", {31'd0, m_write}, 32'd0);

    // Bounce, period 1
    csr_write(2'd1, 32'd1);
    wlog_data.delete(); wlog_cyc.delete();
    csr_write(2'd0, 32'd7);
    wait_writes("bounce", 8, 100);
    exp_q = '{32'd1, 32'd2, 32'd4, 32'd8, 32'd4, 32'd2, 32'd1, 32'd2};
    check_log("bounce", 2);
    csr_write(2'd0, 32'd0);
    tick(10);

    // Stalled write: outputs hold, busy set, STEPS increments once
    csr_write(2'd1, 32'd2);
    m_waitrequest = 1'b1;
    csr_write(2'd0, 32'd1);
    wait_mwrite("stall", 20);
    csr_read(2'd3, steps_before);
    for (int i = 0; i < 7; i++) begin
      check_eq($sformatf("stall_mwrite%0d", i), {31'd0, m_write}, 32'd1);
      check_eq($sformatf("stall_data%0d", i), m_writedata, 32'd1);
      csr_read(2'd2, rd); check_eq($sformatf("stall_status%0d", i), rd, 32'h11);
      tick();
    end
    csr_read(2'd3, rd); check_eq("stall_steps_hold", rd, steps_before);
    m_waitrequest = 1'b0;
    tick();
    m_waitrequest = 1'b1;
    csr_read(2'd3, rd); check_eq("stall_steps_inc", rd, steps_before + 32'd1);

    // Disable while the next write (pattern 2) is stalled
    wait_mwrite("dis", 20);
    tick(2);
    check_eq("dis_pending_data", m_writedata, 32'd2);
    csr_read(2'd3, rd); check_eq("dis_steps_once", rd, steps_before + 32'd1);
    csr_write(2'd0, 32'd0);
    tick(3);
    check_eq("dis_still_mwrite", {31'd0, m_write}, 32'd1);
    check_eq("dis_still_data", m_writedata, 32'd2);
    wlog_data.delete(); wlog_cyc.delete();
    m_waitrequest = 1'b0;
    wait_writes("dis", 2, 20);
    exp_q = '{32'd2, 32'd0};
    check_log("dis", 1);
    tick(3);
    check_eq("dis_idle_mwrite", {31'd0, m_write}, 32'd0);
    csr_read(2'd2, rd); check_eq("dis_idle_status", rd, 32'h20);

    // Blink with PERIOD 0: 15,0 every 2 cycles
    csr_write(2'd1, 32'd0);
    wlog_data.delete(); wlog_cyc.delete();
    csr_write(2'd0, 32'd5);
    wait_writes("blink", 4, 50);
    exp_q = '{32'd15, 32'd0, 32'd15, 32'd0};
    check_log("blink", 2);
    csr_write(2'd0, 32'd0);
    tick(10);

    // Reset during a stalled write
    m_waitrequest = 1'b1;
    csr_write(2'd1, 32'd3);
    csr_write(2'd0, 32'd1);
    wait_mwrite("rstw", 20);
    tick(2);
    reset = 1'b1;
    tick();
    check_eq("rstw_m_write", {31'd0, m_write}, 32'd0);
    check_eq("rstw_m_writedata", m_writedata, 32'd0);
    check_eq("rstw_m_address", {30'd0, m_address}, 32'd0);
    csr_read(2'd0, rd); check_eq("rstw_ctrl", rd, 32'd0);
    csr_read(2'd1, rd); check_eq("rstw_period", rd, 32'd1);
    csr_read(2'd2, rd); check_eq("rstw_status", rd, 32'd0);
    csr_read(2'd3, rd); check_eq("rstw_steps", rd, 32'd0);
    reset = 1'b0;
    m_waitrequest = 1'b0;
    tick(3);
    check_eq("rstw_idle_mwrite", {31'd0, m_write}, 32'd0);

    // Writes to read-only registers are ignored
    csr_write(2'd3, 32'h55);
    csr_write(2'd2, 32'hFF);
    csr_read(2'd3, rd); check_eq("ro_steps", rd, 32'd0);
    csr_read(2'd2, rd); check_eq("ro_status", rd, 32'd0);
    check_eq("ro_mwrite", {31'd0, m_write}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
